// File: rtl/otter_mem_load_unit.sv
// Multi-cycle data-memory access unit: issues byte/half/word loads and stores
// on a req/ack bus, stalls the core while a transaction is outstanding and
// returns an aligned, sign- or zero-extended load result for write-back.
module otter_mem_load_unit #(
    parameter int unsigned TIMEOUT = 16   // max REQ cycles waiting for ack; 0 disables
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        mem_rden,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sign_n,
    output logic        stall,
    output logic        done,
    output logic        err_illegal,
    output logic        err_timeout,
    output logic [31:0] DOUT2,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Counter only needs to reach TIMEOUT-1: the last REQ cycle is detected
    // while the counter holds that value.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    logic [1:0]         size_q;
    logic               sign_n_q;
    logic               err_illegal_q;
    logic               err_timeout_q;

    logic               start;
    logic               illegal;
    logic               timeout_hit;
    logic [3:0]         be_next;
    logic [31:0]        wdata_next;
    logic [31:0]        sh;
    logic [31:0]        load_val;

    assign start       = mem_rden | mem_we;
    assign illegal     = (mem_rden & mem_we)
                       | (size == 2'b11)
                       | ((size == SZ_HALF) & addr[0])
                       | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(LAST));

    assign bus_req     = (state == REQ);
    assign done        = (state == DONE);
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (size)
            SZ_BYTE: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Align the returned word to the latched offset and extend to 32 bits.
    always_comb begin
        sh       = bus_rdata >> {off_q, 3'b000};
        load_val = bus_rdata;
        case (size_q)
            SZ_BYTE: load_val = {{24{sh[7] & ~sign_n_q}}, sh[7:0]};
            SZ_HALF: load_val = {{16{sh[15] & ~sign_n_q}}, sh[15:0]};
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
        end
    end

    // Next-state decode and stall generation.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_next = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields, latched request attributes, timeout counter, load result and error flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_be        <= '0;
            bus_wdata     <= '0;
            off_q         <= '0;
            size_q        <= '0;
            sign_n_q      <= 1'b0;
            cnt           <= '0;
            DOUT2         <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // Error flags are set only on the edge entering DONE, so they last one cycle.
            err_illegal_q <= (state == IDLE) && start && illegal;
            err_timeout_q <= (state == REQ) && !bus_ack && timeout_hit;
            case (state)
                IDLE: begin
                    if (start && !illegal) begin
                        bus_we    <= mem_we;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= be_next;
                        bus_wdata <= wdata_next;
                        off_q     <= addr[1:0];
                        size_q    <= size;
                        sign_n_q  <= sign_n;
                        cnt       <= '0;
                    end else if (start && mem_rden) begin
                        DOUT2 <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            DOUT2 <= load_val;
                        end
                        bus_we <= 1'b0;
                        cnt    <= '0;
                    end else if (timeout_hit) begin
                        if (!bus_we) begin
                            DOUT2 <= '0;
                        end
                        bus_we <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_load_unit.sv
// Scoreboard bench for otter_mem_load_unit: stimulus pushes expected bus
// requests and completions into queues; an independent monitor pops and
// compares whenever the DUT raises bus_req or done.
module tb_otter_mem_load_unit;

    localparam int unsigned TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        mem_rden = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = '0;
    logic        sign_n = 1'b0;
    logic        stall;
    logic        done;
    logic        err_illegal;
    logic        err_timeout;
    logic [31:0] DOUT2;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    otter_mem_load_unit #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .mem_rden(mem_rden), .mem_we(mem_we), .addr(addr), .wdata(wdata),
        .size(size), .sign_n(sign_n),
        .stall(stall), .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout),
        .DOUT2(DOUT2),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } exp_bus_t;

    typedef struct {
        int          cyc;
        logic        ill;
        logic        to;
        logic [31:0] dout;
        int          stall_cycles;
        int          req_cycles;
    } exp_done_t;

    exp_bus_t    bus_q[$];
    exp_done_t   done_q[$];
    logic [31:0] model_dout = '0;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference load extraction from the architectural rules.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                              input logic [1:0] sz, input bit sn);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (!sn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!sn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // One request; ack_cycle = REQ cycle (1-based) carrying bus_ack, 0 = never.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input bit sn,
                           input logic [31:0] rdata, input int ack_cycle);
        bit        is_ill;
        bit        timed_out;
        int        off;
        int        lat;
        exp_bus_t  b;
        exp_done_t e;
        off       = int'(a[1:0]);
        is_ill    = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && off != 0);
        timed_out = (ack_cycle == 0);
        @(posedge CLK); #1;
        mem_rden = rd; mem_we = wr; addr = a; wdata = wd; size = sz; sign_n = sn;
        e.ill = is_ill;
        e.to  = 1'b0;
        if (is_ill) begin
            if (rd) model_dout = '0;
            lat          = 1;
            e.req_cycles = 0;
        end else begin
            b.addr = a & 32'hFFFF_FFFC;
            b.we   = wr;
            if (sz == 2'b00) begin
                b.be    = 4'(1 << off);
                b.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
            end else if (sz == 2'b01) begin
                b.be    = 4'(3 << off);
                b.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
            end else begin
                b.be    = 4'hF;
                b.wdata = wd;
            end
            bus_q.push_back(b);
            if (timed_out) begin
                e.to         = 1'b1;
                e.req_cycles = TIMEOUT;
                lat          = TIMEOUT + 1;
                if (rd) model_dout = '0;
            end else begin
                e.req_cycles = ack_cycle;
                lat          = ack_cycle + 1;
                if (rd) model_dout = ref_load(rdata, off, sz, sn);
            end
        end
        e.cyc          = cyc + lat;
        e.dout         = model_dout;
        e.stall_cycles = lat;
        done_q.push_back(e);
        @(posedge CLK); #1;
        mem_rden = 1'b0; mem_we = 1'b0;
        addr = $urandom; wdata = $urandom; size = 2'($urandom); sign_n = 1'($urandom);
        if (!is_ill) begin
            for (int k = 1; k <= int'(TIMEOUT); k++) begin
                bus_ack   = (k == ack_cycle);
                bus_rdata = (k == ack_cycle) ? rdata : $urandom;
                // Requests arriving mid-transaction must be ignored.
                mem_rden  = 1'($urandom);
                mem_we    = 1'($urandom);
                @(posedge CLK); #1;
                bus_ack  = 1'b0;
                mem_rden = 1'b0;
                mem_we   = 1'b0;
                if (k == ack_cycle) break;
            end
        end
    endtask

    // Monitor: compares bus requests and completions against the queues.
    initial begin : monitor
        int       stall_cnt;
        int       req_cnt;
        bit       prev_req;
        exp_bus_t cur;
        exp_done_t e;
        stall_cnt = 0; req_cnt = 0; prev_req = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                stall_cnt = 0; req_cnt = 0; prev_req = 1'b0;
            end else begin
                if (stall) stall_cnt++;
                if (bus_req) begin
                    if (!prev_req) begin
                        if (bus_q.size() == 0) check("spurious_bus_req", bus_req, 1'b0);
                        else cur = bus_q.pop_front();
                    end
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_be", bus_be, cur.be);
                    check("bus_we", bus_we, cur.we);
                    if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
                    req_cnt++;
                end
                prev_req = bus_req;
                if (done) begin
                    if (done_q.size() == 0) begin
                        check("spurious_done", done, 1'b0);
                    end else begin
                        e = done_q.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("err_illegal", err_illegal, e.ill);
                        check("err_timeout", err_timeout, e.to);
                        check("DOUT2", DOUT2, e.dout);
                        check("stall_cycles", stall_cnt, e.stall_cycles);
                        check("req_cycles", req_cnt, e.req_cycles);
                        check("stall_in_done", stall, 1'b0);
                        check("req_in_done", bus_req, 1'b0);
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end else begin
                    check("err_outside_done", {err_illegal, err_timeout}, 2'b00);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        int          ack;
        bit          rd;
        bit          wr;
        exp_bus_t    b;

        // Reset state.
        #2;
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_errs", {err_illegal, err_timeout}, 2'b00);
        check("rst_DOUT2", DOUT2, 32'h0);
        check("rst_bus_fields", {bus_we, bus_be}, 5'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Directed cases.
        run_txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 3);
        run_txn(1, 0, 32'h203, 32'h0, 2'b00, 0, 32'h8011_2233, 1);
        run_txn(1, 0, 32'h203, 32'h0, 2'b00, 1, 32'h8011_2233, 1);
        run_txn(0, 1, 32'h302, 32'h0000_ABCD, 2'b01, 0, 32'h0, 1);
        run_txn(1, 0, 32'h101, 32'h0, 2'b10, 0, 32'h0, 1);
        run_txn(1, 0, 32'h400, 32'h0, 2'b10, 0, 32'h1234_5678, 2);
        run_txn(1, 0, 32'h400, 32'h0, 2'b11, 0, 32'h0, 1);
        run_txn(1, 0, 32'h404, 32'h0, 2'b01, 0, 32'h0000_8001, 1);
        run_txn(1, 1, 32'h404, 32'h0, 2'b10, 0, 32'h0, 1);
        run_txn(1, 0, 32'h406, 32'h0, 2'b01, 0, 32'h9ABC_0000, 2);
        run_txn(0, 1, 32'h501, 32'h1, 2'b01, 0, 32'h0, 1);
        run_txn(1, 0, 32'h600, 32'h0, 2'b10, 0, 32'h0, 0);
        run_txn(1, 0, 32'h604, 32'h0, 2'b10, 0, 32'hCAFE_F00D, 16);
        run_txn(0, 1, 32'h700, 32'h5555_AAAA, 2'b10, 0, 32'h0, 0);

        // Randomised mix of loads, stores, illegal requests and timeouts.
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 7));
            rd = (r <= 4) || (r == 7);
            wr = (r >= 5);
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            ack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            run_txn(rd, wr, a, $urandom, sz, 1'($urandom), $urandom, ack);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end

        // Load with a known result so the reset below visibly clears DOUT2.
        run_txn(1, 0, 32'h800, 32'h0, 2'b10, 0, 32'hDEAD_BEEF, 1);
        repeat (2) @(posedge CLK);

        // Reset in the middle of REQ.
        @(posedge CLK); #1;
        mem_rden = 1'b1; addr = 32'h900; size = 2'b10; sign_n = 1'b0;
        b.addr = 32'h900; b.be = 4'hF; b.we = 1'b0; b.wdata = '0;
        bus_q.push_back(b);
        @(posedge CLK); #1;
        mem_rden = 1'b0;
        @(posedge CLK); #1;
        check("pre_rst_DOUT2", DOUT2, 32'hDEAD_BEEF);
        check("pre_rst_req", bus_req, 1'b1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_bus_req", bus_req, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_DOUT2", DOUT2, 32'h0);
        check("mid_rst_bus_addr", bus_addr, 32'h0);
        model_dout = '0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        run_txn(1, 0, 32'hA02, 32'h0, 2'b01, 0, 32'hF00F_1234, 2);

        // Drain: every pushed expectation must have been consumed.
        for (int i = 0; i < 50; i++) begin
            if (done_q.size() == 0 && bus_q.size() == 0) break;
            @(posedge CLK);
        end
        @(negedge CLK);
        check("done_queue_drained", done_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/otter_mem_load_unit.md
Name: otter_mem_load_unit

Overview:
- Multi-cycle data-memory access unit between the execute stage and the register-file write mux.
- For stores, it drives a request/acknowledge data bus with byte enables and lane-replicated write data.
- For loads, it produces the aligned, sign- or zero-extended load word `DOUT2`, which the write-back mux selects when `rf_wr_sel` = 2'b10.
- It stalls the core while a bus transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum `REQ` cycles to wait for `bus_ack`; 0 disables the timeout.

Ports:
- `CLK` input 1: system clock, rising edge.
- `RST_N` input 1: asynchronous active-low reset.
- `mem_rden` input 1: load request pulse, sampled only in `IDLE`.
- `mem_we` input 1: store request pulse, sampled only in `IDLE`.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-justified.
- `size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `sign_n` input 1: 1 = unsigned load (LBU/LHU).
- `stall` output 1: freeze PC/pipeline.
- `done` output 1: one-cycle completion pulse.
- `err_illegal` output 1: completion with illegal request.
- `err_timeout` output 1: completion with bus timeout.
- `DOUT2` output 32: load result to the write-back mux.
- `bus_req` output 1: bus request.
- `bus_we` output 1: bus write.
- `bus_addr` output 32: word-aligned address, {`addr`[31:2], 2'b00}.
- `bus_be` output 4: byte enables.
- `bus_wdata` output 32: lane-replicated store data.
- `bus_ack` input 1: bus completion, valid only while `bus_req` = 1.
- `bus_rdata` input 32: read data, valid with `bus_ack`.

Behaviour:
- Reset (async, `RST_N` = 0): state `IDLE`; all of the following are 0 immediately, with no bus cycle completed:
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`
  - `DOUT2`, `done`, `err_*`
  - timeout counter
- Reset mid-transaction has the same effect.
- FSM states: `IDLE`, `REQ`, `DONE`.
- `IDLE`:
  - start = `mem_rden` | `mem_we`.
  - `stall` = start (combinational).
  - On a legal start: register the bus fields and the latched offset/size/sign; go to `REQ`.
  - On an illegal start: issue no bus request; go to `DONE` with `err_illegal`.
- Illegal requests:
  - `size` = 11.
  - Half with `addr`[0] = 1.
  - Word with `addr`[1:0] ≠ 0.
  - `mem_rden` & `mem_we` both asserted.
- `REQ`:
  - `bus_req` = 1; `stall` = 1.
  - All bus outputs are held stable until ack.
  - Counter increments each `REQ` cycle.
  - `bus_ack` = 1: capture the result and go to `DONE`.
  - Counter reaches `TIMEOUT` (≠ 0) without ack: drop `bus_req`; go to `DONE` with `err_timeout`; `DOUT2` ← 0.
  - If ack arrives in the same cycle as the timeout, ack wins.
- `DONE`:
  - `done` = 1; `stall` = 0; the error flag is valid for this cycle only.
  - Next state is `IDLE`.
  - `mem_rden`/`mem_we` are ignored in `DONE` and `REQ`, with no bus activity.
- Minimum latency: start in cycle 0, ack in cycle 1, `done` in cycle 2. `stall` is high in cycles 0–1.
- Byte enables: byte = 4'b0001 << off; half = 4'b0011 << off; word = 4'b1111 (off = `addr`[1:0]).
- Store data: byte = {4{`wdata`[7:0]}}; half = {2{`wdata`[15:0]}}; word = `wdata`.
- Load extraction:
  - sh = `bus_rdata` >> (8·off).
  - Byte: `DOUT2` = sign-extend or zero-extend of sh[7:0].
  - Half: `DOUT2` = sign-extend or zero-extend of sh[15:0].
  - Word: `DOUT2` = `bus_rdata`.
- `DOUT2` is registered and updates only on load ack, load timeout (→ 0), or illegal load (→ 0).
- `DOUT2` holds its value through stores and `IDLE`.
- `bus_we` = 1 only for stores.
- `bus_req` never asserts in `IDLE` or `DONE`.

Test Plan:
- Word load: `addr` = 0x100, `size` = 10, `bus_rdata` = 0xDEADBEEF, ack after 3 `REQ` cycles.
  - `bus_addr` = 0x100, `bus_be` = 1111.
  - `stall` high for 4 cycles, then `done`.
  - `DOUT2` = 0xDEADBEEF.
- Byte loads at `addr` = 0x203, `bus_rdata` = 0x80112233:
  - Signed: `bus_be` = 1000, `DOUT2` = 0xFFFFFF80.
  - `sign_n` = 1: `DOUT2` = 0x00000080.
- Half store at `addr` = 0x302, `wdata` = 0x0000ABCD, immediate ack:
  - `bus_we` = 1, `bus_be` = 1100, `bus_wdata` = 0xABCDABCD.
  - `done` in cycle 2; `DOUT2` unchanged.
- Illegal requests:
  - Word load at 0x101 → no `bus_req`; `done` + `err_illegal` in cycle 1; `DOUT2` = 0.
  - Same result for `size` = 11, and for `mem_rden` & `mem_we` both high.
- Timeout, `TIMEOUT` = 16, `bus_ack` never asserted:
  - `bus_req` high exactly 16 cycles.
  - Then `done` + `err_timeout`; `DOUT2` = 0.
  - Ack on cycle 16 instead → normal completion.
- Reset mid-`REQ`: `RST_N` low in cycle 2 of a load.
  - `bus_req`, `stall`, `DOUT2` go to 0 without a clock edge.
  - After release, a new load completes normally.
